// File: rtl/k2_fetch_ctrl.sv
// k2_fetch_ctrl: instruction-fetch and execution controller for the K2 core.
// Holds the program memory and serves instruction_data combinationally for the
// core's ProgramAddress. Generates the PC_en advance strobe in three modes:
// free-run (prescaled), single-step (button) or halt.
// The optional breakpoint feature is enabled by defining K2_BREAKPOINT_EN,
// which adds the bp_en / bp_addr ports.
module k2_fetch_ctrl #(
  parameter int ADDR_BITS  = 4,
  parameter int INSTR_BITS = 8,
  parameter int DIV_WIDTH  = 24,
  parameter int DIV_MAX    = 12_499_999
) (
  input  logic                  clk,
  input  logic                  rst_n,   // active-high asynchronous reset
  input  logic                  run_mode,
  input  logic                  step_btn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  prog_we,
  input  logic [ADDR_BITS-1:0]  prog_addr,
  input  logic [INSTR_BITS-1:0] prog_data,
  input  logic [ADDR_BITS-1:0]  ProgramAddress,
`ifdef K2_BREAKPOINT_EN
  input  logic                  bp_en,
  input  logic [ADDR_BITS-1:0]  bp_addr,
`endif
  output logic [INSTR_BITS-1:0] instruction_data,
  output logic                  PC_en,
  output logic                  halted,
  output logic [1:0]            state
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [DIV_WIDTH-1:0] DIV_MAX_V = DIV_WIDTH'(DIV_MAX);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic [DIV_WIDTH-1:0]           r_presc;
  logic                           r_run_mode;
  logic                           w_mode_change;
  logic                           r_pc_en_d;
  logic                           r_sync1;
  logic                           r_sync2;
  logic                           r_sync3;
  logic                           r_step_pulse;
  logic                           w_selfjmp;
  logic                           w_pc_raw;
  logic                           w_pc_en;
  logic                           w_mem_we;
  logic [DEPTH-1:0][INSTR_BITS-1:0] w_mem;
`ifdef K2_BREAKPOINT_EN
  logic                           w_bp_hit;
  logic                           r_bp_halt;
  logic                           r_skip;
`endif

  // Program memory: one register per word so the whole array clears on reset.
  // Writes are only accepted while the core is stopped in LOAD.
  assign w_mem_we = prog_we && (r_state == S_LOAD);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      logic [INSTR_BITS-1:0] r_word;
      // Store one program word.
      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          r_word <= '0;
        end else if (w_mem_we && (prog_addr == ADDR_BITS'(gi))) begin
          r_word <= prog_data;
        end
      end
      assign w_mem[gi] = r_word;
    end
  endgenerate

  assign instruction_data = w_mem[ProgramAddress];

  // A jump whose target equals its own address parks the core: opcode 10_00,
  // target in the low three bits, only reachable from the lower half.
  assign w_selfjmp = instruction_data[7] && !instruction_data[6] &&
                     (instruction_data[5:4] == 2'b00) && !ProgramAddress[3] &&
                     (instruction_data[2:0] == ProgramAddress[2:0]);

  // Mode input is registered, so a toggle acts one cycle later; the change
  // cycle itself restarts the prescaler.
  assign w_mode_change = (run_mode != r_run_mode);

  // Step button: two-flop synchronizer, edge detect, registered pulse
  // (3 cycles from button edge to PC_en).
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_sync1      <= step_btn;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_step_pulse <= r_sync2 && !r_sync3;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and PC_en decode; stop has priority, then self-jump, then advance.
  always_comb begin
    w_state_next = r_state;
    w_pc_raw     = 1'b0;
    w_pc_en      = 1'b0;
`ifdef K2_BREAKPOINT_EN
    w_bp_hit     = 1'b0;
`endif
    case (r_state)
      S_LOAD: begin
        if (start && !stop) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_next = S_LOAD;
        end else if (w_selfjmp) begin
          w_state_next = S_HALT;
        end else begin
          // r_pc_en_d guard keeps the strobe single-cycle even across a mode switch
          w_pc_raw = (r_run_mode ? (r_presc == DIV_MAX_V) : r_step_pulse) && !r_pc_en_d;
`ifdef K2_BREAKPOINT_EN
          w_bp_hit = w_pc_raw && bp_en && (ProgramAddress == bp_addr) && !r_skip;
          if (w_bp_hit) begin
            w_state_next = S_HALT;
          end
          w_pc_en = w_pc_raw && !w_bp_hit;
`else
          w_pc_en = w_pc_raw;
`endif
        end
      end
      S_HALT: begin
        if (stop) begin
          w_state_next = S_LOAD;
        end else if (start) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
  end

  // Prescaler counts only while staying in free-run RUN; any entry, exit or
  // mode change restarts it from zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_presc    <= '0;
      r_run_mode <= 1'b0;
      r_pc_en_d  <= 1'b0;
    end else begin
      r_run_mode <= run_mode;
      r_pc_en_d  <= w_pc_en;
      if ((r_state == S_RUN) && (w_state_next == S_RUN) && r_run_mode && !w_mode_change) begin
        r_presc <= (r_presc == DIV_MAX_V) ? '0 : r_presc + 1'b1;
      end else begin
        r_presc <= '0;
      end
    end
  end

`ifdef K2_BREAKPOINT_EN
  // Remember a breakpoint halt; resuming from it lets the first advance through.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_bp_halt <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      r_bp_halt <= ((r_state == S_HALT) && (w_state_next == S_HALT)) ? r_bp_halt : w_bp_hit;
      if (stop) begin
        r_skip <= 1'b0;
      end else if ((r_state == S_HALT) && start && r_bp_halt) begin
        r_skip <= 1'b1;
      end else if (w_pc_en) begin
        r_skip <= 1'b0;
      end
    end
  end
`endif

  assign PC_en  = w_pc_en;
  assign halted = (r_state == S_HALT);
  assign state  = r_state;

endmodule

// File: tb/tb_k2_fetch_ctrl.sv
// tb_k2_fetch_ctrl: directed and randomized checks of k2_fetch_ctrl against a
// cycle-level behavioural model. Breakpoint checks are compiled in when
// K2_BREAKPOINT_EN is defined.
module tb_k2_fetch_ctrl;

  localparam int DIVM   = 3;
  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run_mode = 1'b0;
  logic       step_btn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'h0;
  logic [7:0] prog_data = 8'h00;
  logic [3:0] pa = 4'h0;
  logic [7:0] instruction_data;
  logic       PC_en;
  logic       halted;
  logic [1:0] state;
`ifdef K2_BREAKPOINT_EN
  logic       bp_en = 1'b0;
  logic [3:0] bp_addr = 4'h0;
  logic       m_skip;
  logic       m_bphalt;
`endif

  int n_total = 0;
  int n_bad   = 0;
  int pc_seen = 0;

  // behavioural model
  int         m_state;
  logic [7:0] m_mem [16];
  int         m_age;        // consecutive free-run counting cycles
  logic       m_prev_mode;
  logic       m_prev_pc;
  logic [4:1] m_btn;        // m_btn[k] = button value k cycles ago

  always #5 clk = ~clk;

  k2_fetch_ctrl #(
    .ADDR_BITS(4), .INSTR_BITS(8), .DIV_WIDTH(24), .DIV_MAX(DIVM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_mode(run_mode), .step_btn(step_btn),
    .start(start), .stop(stop), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .ProgramAddress(pa),
`ifdef K2_BREAKPOINT_EN
    .bp_en(bp_en), .bp_addr(bp_addr),
`endif
    .instruction_data(instruction_data), .PC_en(PC_en), .halted(halted), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state     = M_LOAD;
    m_age       = 0;
    m_prev_mode = 1'b0;
    m_prev_pc   = 1'b0;
    m_btn       = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
`ifdef K2_BREAKPOINT_EN
    m_skip   = 1'b0;
    m_bphalt = 1'b0;
`endif
  endtask

  // Called just after a negedge with inputs set; checks this cycle, advances
  // the model across the posedge and returns at the next negedge.
  task automatic cyc();
    logic [7:0] instr;
    logic       sj, pulse, raw, hit, exp_pc;
    int         nxt;
    #1;
    instr = m_mem[pa];
    sj    = instr[7] && !instr[6] && (instr[5:4] == 2'b00) && !pa[3] && (instr[2:0] == pa[2:0]);
    pulse = m_btn[3] && !m_btn[4];
    raw   = (m_state == M_RUN) && !stop && !sj && !m_prev_pc &&
            (m_prev_mode ? ((m_age % (DIVM + 1)) == DIVM) : pulse);
    hit   = 1'b0;
`ifdef K2_BREAKPOINT_EN
    hit   = raw && bp_en && (pa == bp_addr) && !m_skip;
`endif
    exp_pc = raw && !hit;
    nxt = m_state;
    if (m_state == M_LOAD) begin
      if (start && !stop) nxt = M_RUN;
    end else if (m_state == M_RUN) begin
      if (stop) nxt = M_LOAD;
      else if (sj || hit) nxt = M_HALT;
    end else begin
      if (stop) nxt = M_LOAD;
      else if (start) nxt = M_RUN;
    end
    chk("state", 32'(state), 32'(m_state));
    chk("pc_en", 32'(PC_en), 32'(exp_pc));
    chk("halted", 32'(halted), 32'(m_state == M_HALT));
    chk("instr", 32'(instruction_data), 32'(instr));
    if (PC_en) pc_seen++;
    @(posedge clk);
    if (prog_we && (m_state == M_LOAD)) m_mem[prog_addr] = prog_data;
    m_age = ((m_state == M_RUN) && (nxt == M_RUN) && m_prev_mode && (run_mode == m_prev_mode)) ?
            m_age + 1 : 0;
`ifdef K2_BREAKPOINT_EN
    if (stop) m_skip = 1'b0;
    else if ((m_state == M_HALT) && start && m_bphalt) m_skip = 1'b1;
    else if (exp_pc) m_skip = 1'b0;
    if (!((m_state == M_HALT) && (nxt == M_HALT))) m_bphalt = hit;
`endif
    m_prev_mode = run_mode;
    m_prev_pc   = exp_pc;
    m_btn[4] = m_btn[3];
    m_btn[3] = m_btn[2];
    m_btn[2] = m_btn[1];
    m_btn[1] = step_btn;
    m_state  = nxt;
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b1;
    #1;
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_pc_en"}, 32'(PC_en), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_instr"}, 32'(instruction_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    $display("reset %s done", tag);
  endtask

  task automatic pulse_ctl(input logic s_start, input logic s_stop);
    start = s_start;
    stop  = s_stop;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    model_reset();
    @(negedge clk);
    do_reset("por");

    // 1: program load and read-back; writes outside LOAD are dropped
    for (int i = 0; i < 3; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = 8'(8'h11 * (i + 1));
      cyc();
      $display("load write addr=%0d data=%02h", i, prog_data);
    end
    prog_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pa = 4'(i);
      cyc();
      $display("read addr=%0d data=%02h", i, instruction_data);
    end
    pa = 4'h0;
    pulse_ctl(1'b1, 1'b0);
    prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'hFF;
    cyc(); cyc();
    prog_we = 1'b0;
    pulse_ctl(1'b0, 1'b1);
    cyc();
    chk("t1_run_write_ignored", 32'(instruction_data), 32'h11);
    $display("run-state write attempt, mem[0]=%02h", instruction_data);

    // 2: free-run with DIV_MAX=3, stop on cycle 9
    run_mode = 1'b1;
    cyc();
    pc_seen = 0;
    pulse_ctl(1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) cyc();
    chk("t2_pulses_before_stop", 32'(pc_seen), 32'd2);
    pulse_ctl(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc();
    chk("t2_pulses_after_stop", 32'(pc_seen), 32'd2);
    $display("free-run pulses=%0d", pc_seen);

    // 3: single-step, two 10-cycle presses
    run_mode = 1'b0;
    cyc();
    pulse_ctl(1'b1, 1'b0);
    pc_seen = 0;
    for (int p = 0; p < 2; p++) begin
      step_btn = 1'b1;
      for (int i = 0; i < 10; i++) cyc();
      step_btn = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
    end
    chk("t3_step_pulses", 32'(pc_seen), 32'd2);
    $display("step pulses=%0d", pc_seen);
    pulse_ctl(1'b0, 1'b1);

    // 4: self-jump halt, restart re-halts, stop back to LOAD
    prog_we = 1'b1; prog_addr = 4'h5; prog_data = 8'h85;
    cyc();
    prog_we = 1'b0;
    pa = 4'h5;
    pulse_ctl(1'b1, 1'b0);
    cyc();
    chk("t4_halted", 32'(halted), 32'd1);
    pulse_ctl(1'b1, 1'b0);
    cyc();
    chk("t4_rehalt", 32'(state), 32'd2);
    pulse_ctl(1'b0, 1'b1);
    chk("t4_load", 32'(state), 32'd0);
    $display("self-jump halt/restart/stop state=%0d", state);

    // 5: simultaneous start+stop from HALT, then reset mid-RUN
    pulse_ctl(1'b1, 1'b0);
    cyc();
    pulse_ctl(1'b1, 1'b1);
    chk("t5_start_stop", 32'(state), 32'd0);
    pa = 4'h0;
    run_mode = 1'b1;
    cyc();
    pulse_ctl(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    do_reset("midrun");
    for (int i = 0; i < 3; i++) begin
      pa = 4'(i);
      cyc();
    end
    $display("start+stop and mid-run reset done");

`ifdef K2_BREAKPOINT_EN
    // 6: breakpoint at address 2, resume steps past it once
    pa = 4'h0; run_mode = 1'b1; bp_en = 1'b1; bp_addr = 4'h2;
    cyc();
    pulse_ctl(1'b1, 1'b0);
    hold = 0;
    while ((m_state != M_HALT) && (hold < 40)) begin
      if (m_prev_pc) pa = pa + 4'h1;
      cyc();
      hold++;
    end
    chk("t6_bp_halt", 32'(state), 32'd2);
    chk("t6_bp_addr", 32'(pa), 32'd2);
    pulse_ctl(1'b1, 1'b0);
    hold = 0;
    while ((pa != 4'h3) && (hold < 20)) begin
      if (m_prev_pc) pa = pa + 4'h1;
      cyc();
      hold++;
    end
    chk("t6_resume_addr", 32'(pa), 32'd3);
    pulse_ctl(1'b0, 1'b1);
    bp_en = 1'b0;
    $display("breakpoint halt and resume at addr=%0d", pa);
`endif

    // randomized traffic
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      prog_we = ($urandom_range(0, 3) == 0);
      prog_addr = 4'($urandom);
      if ($urandom_range(0, 2) == 0)
        prog_data = {4'b1000, 1'($urandom), prog_addr[2:0]};
      else
        prog_data = 8'($urandom);
      if ($urandom_range(0, 99) == 0) run_mode = ~run_mode;
      if (hold == 0) begin
        step_btn = ~step_btn;
        hold = $urandom_range(1, 8);
      end else begin
        hold--;
      end
      if (m_prev_pc) pa = pa + 4'h1;
      if ($urandom_range(0, 15) == 0) pa = 4'($urandom);
`ifdef K2_BREAKPOINT_EN
      bp_en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) bp_addr = 4'($urandom);
`endif
      if (i == 750) begin
        do_reset("random");
      end
      cyc();
      if ((i % 250) == 249) $display("random batch end i=%0d state=%0d", i, state);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
